// File: rtl/reg_file_param.sv
// Parametrised register file: DEPTH x WIDTH storage, one byte-maskable write port,
// two combinational read ports, optional hardwired-zero r0, optional write-to-read
// bypass, and a per-register busy scoreboard for multi-cycle producers.
module reg_file_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned NB      = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [NB-1:0]    wbe,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    output logic             rbusy1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata2,
    output logic             rbusy2,
    input  logic             mark_busy,
    input  logic [AW-1:0]    mark_addr
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_wr_merged;
    logic             w_wr_hit;
    logic             w_mk_hit;
    logic [AW-1:0]    w_widx;
    logic [AW-1:0]    w_midx;
    logic [AW-1:0]    w_raddr [2];
    logic [WIDTH-1:0] w_rdata [2];
    logic             w_rbusy [2];

    // Address names a real, writable register (in range and not the hardwired zero).
    function automatic logic addr_live(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Clamp an address into the array so out-of-range values never index past the end.
    function automatic logic [AW-1:0] safe_idx(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) ? a : '0;
    endfunction

    // Expand byte-lane enables into a bit mask.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < int'(NB); i++) begin
            w_mask[8*i +: 8] = {8{wbe[i]}};
        end
    end

    // Write/mark qualification; gated by rst_n so nothing bypasses while reset is held.
    always_comb begin
        w_wr_hit    = rst_n && we && addr_live(waddr);
        w_mk_hit    = rst_n && mark_busy && addr_live(mark_addr);
        w_widx      = safe_idx(waddr);
        w_midx      = safe_idx(mark_addr);
        w_wr_merged = (r_mem[w_widx] & ~w_mask) | (wdata & w_mask);
    end

    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    // Read ports: stored value, optionally overlaid with the in-flight write.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = '0;
            w_rbusy[p] = 1'b0;
            if (rst_n && addr_live(w_raddr[p])) begin
                w_rdata[p] = r_mem[safe_idx(w_raddr[p])];
                w_rbusy[p] = r_busy[safe_idx(w_raddr[p])];
                if ((BYPASS != 0) && w_wr_hit && (waddr == w_raddr[p])) begin
                    w_rdata[p] = (w_rdata[p] & ~w_mask) | (wdata & w_mask);
                    // A same-cycle mark re-arms busy: new producer wins.
                    w_rbusy[p] = w_mk_hit && (mark_addr == w_raddr[p]);
                end
            end
        end
    end

    assign rdata1 = w_rdata[0];
    assign rbusy1 = w_rbusy[0];
    assign rdata2 = w_rdata[1];
    assign rbusy2 = w_rbusy[1];

    // State update; mark is applied after the write-back clear so it wins on a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_hit) begin
                r_mem[w_widx]  <= w_wr_merged;
                r_busy[w_widx] <= 1'b0;
            end
            if (w_mk_hit) begin
                r_busy[w_midx] <= 1'b1;
            end
        end
    end

endmodule
